// File: rtl/receptor_nota_serial_pkg.sv
// Shared constants for the serial note receiver and the challenge-mode game FSM:
// ASCII note codes, 3-bit note encodings and the receiver state type.
package receptor_nota_serial_pkg;

    localparam logic [7:0] NOTA_A_ASCII = 8'd97;
    localparam logic [7:0] NOTA_B_ASCII = 8'd98;
    localparam logic [7:0] NOTA_C_ASCII = 8'd99;
    localparam logic [7:0] NOTA_D_ASCII = 8'd100;

    localparam logic [2:0] NOTA_NINGUNA = 3'd0;
    localparam logic [2:0] NOTA_A       = 3'd1;
    localparam logic [2:0] NOTA_B       = 3'd2;
    localparam logic [2:0] NOTA_C       = 3'd3;
    localparam logic [2:0] NOTA_D       = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_HOLD
    } estado_rx_t;

    function automatic logic es_nota_valida(input logic [7:0] b);
        return (b >= NOTA_A_ASCII) && (b <= NOTA_D_ASCII);
    endfunction

    function automatic logic [2:0] codificar_nota(input logic [7:0] b);
        return es_nota_valida(b) ? 3'(b - NOTA_A_ASCII + 8'd1) : NOTA_NINGUNA;
    endfunction

endpackage

// File: rtl/receptor_nota_serial_if.sv
// Receiver-side bus: serial line in, held note byte and status pulses out.
// The master modport is the receiver itself; slave is its consumer/driver.
interface receptor_nota_serial_if;
    logic       rx;
    logic [7:0] dato;
    logic       dato_valido;
    logic       error_trama;

    modport master (input rx, output dato, output dato_valido, output error_trama);
    modport slave  (output rx, input dato, input dato_valido, input error_trama);
endinterface

// File: rtl/receptor_nota_serial_sincronizador_rx.sv
// Two-flop synchroniser for the asynchronous RX pin plus a falling-edge strobe.
// All flops reset to 1 (idle line) so leaving reset never looks like a start bit.
module sincronizador_rx (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_rx,
    output logic o_rx_s,
    output logic o_caida
);
    logic r_meta, r_sync, r_prev;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_rx;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rx_s  = r_sync;
    assign o_caida = r_prev & ~r_sync;
endmodule

// File: rtl/receptor_nota_serial.sv
// UART 8N1 receiver presenting each byte as a level held for HOLD_CYCLES.
// Define FILTRO_NOTAS_EN to accept only the note bytes 'a'..'d'.
module receptor_nota_serial
    import receptor_nota_serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208,
    parameter int HOLD_CYCLES  = 25_000_000
) (
    input  logic                  clk,
    input  logic                  reset,
    receptor_nota_serial_if.master bus
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [BW-1:0] W_MITAD   = BW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] W_FIN_BIT = BW'(CLKS_PER_BIT - 1);
    localparam logic [HW-1:0] W_FIN_HLD = HW'(HOLD_CYCLES - 1);

    logic w_rx_s, w_caida, w_aceptar;

    estado_rx_t     r_estado;
    logic [BW-1:0]  r_cnt;
    logic [HW-1:0]  r_hold;
    logic [2:0]     r_idx;
    logic [7:0]     r_byte;
    logic [7:0]     r_dato;
    logic           r_valido, r_error;

    sincronizador_rx u_sinc (
        .i_clk   (clk),
        .i_rst   (reset),
        .i_rx    (bus.rx),
        .o_rx_s  (w_rx_s),
        .o_caida (w_caida)
    );

`ifdef FILTRO_NOTAS_EN
    assign w_aceptar = es_nota_valida(r_byte);
`else
    assign w_aceptar = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_estado <= ST_IDLE;
            r_cnt    <= '0;
            r_hold   <= '0;
            r_idx    <= '0;
            r_byte   <= '0;
            r_dato   <= '0;
            r_valido <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_valido <= 1'b0;
            r_error  <= 1'b0;
            case (r_estado)
                ST_IDLE: begin
                    if (w_caida) begin
                        r_cnt    <= '0;
                        r_estado <= ST_START;
                    end
                end
                ST_START: begin
                    if (r_cnt == W_MITAD) begin
                        r_cnt    <= '0;
                        r_idx    <= '0;
                        r_estado <= w_rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (r_cnt == W_FIN_BIT) begin
                        r_cnt         <= '0;
                        r_byte[r_idx] <= w_rx_s;
                        if (r_idx == 3'd7) r_estado <= ST_STOP;
                        else               r_idx    <= r_idx + 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (r_cnt == W_FIN_BIT) begin
                        r_cnt    <= '0;
                        r_estado <= ST_IDLE;
                        if (!w_rx_s) begin
                            r_error <= 1'b1;
                        end else if (w_aceptar) begin
                            r_dato   <= r_byte;
                            r_valido <= 1'b1;
                            r_hold   <= '0;
                            r_estado <= ST_HOLD;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    // A new start bit wins: drop the note now so the consumer sees a release.
                    if (w_caida) begin
                        r_dato   <= '0;
                        r_cnt    <= '0;
                        r_estado <= ST_START;
                    end else if (r_hold == W_FIN_HLD) begin
                        r_dato   <= '0;
                        r_estado <= ST_IDLE;
                    end else begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
                default: r_estado <= ST_IDLE;
            endcase
        end
    end

    assign bus.dato        = r_dato;
    assign bus.dato_valido = r_valido;
    assign bus.error_trama = r_error;
endmodule

// File: tb/tb_receptor_nota_serial.sv
// Randomised scoreboard bench for receptor_nota_serial (CLKS_PER_BIT=16, HOLD_CYCLES=100).
module tb_receptor_nota_serial;
    localparam int CPB  = 16;
    localparam int HOLD = 100;
    localparam int LAT  = 2 + CPB / 2 + 9 * CPB + 1;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    receptor_nota_serial_if bus ();

    receptor_nota_serial #(.CLKS_PER_BIT(CPB), .HOLD_CYCLES(HOLD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         es_error;
        logic [7:0] valor;
        bit         interrumpido;
    } esp_t;

    esp_t cola[$];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nombre, act, req);
        end
    endtask

    // Reference model: what the frame should produce, from the framing rules alone.
    function automatic bit acepta(input logic [7:0] b);
`ifdef FILTRO_NOTAS_EN
        return (b >= 8'd97) && (b <= 8'd100);
`else
        return 1'b1;
`endif
    endfunction

    task automatic modelo(input logic [7:0] b, input bit stop_ok, input bit interr);
        esp_t e;
        e.valor = b;
        e.interrumpido = interr;
        if (!stop_ok) begin
            e.es_error = 1'b1;
            cola.push_back(e);
        end else if (acepta(b)) begin
            e.es_error = 1'b0;
            cola.push_back(e);
        end
    endtask

    task automatic esperar(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic enviar(input logic [7:0] b, input bit stop_ok);
        bus.rx = 1'b0;
        esperar(CPB);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            esperar(CPB);
        end
        bus.rx = stop_ok;
        esperar(CPB);
        bus.rx = 1'b1;
    endtask

    task automatic enviar_mod(input logic [7:0] b, input bit stop_ok, input bit interr);
        modelo(b, stop_ok, interr);
        enviar(b, stop_ok);
    endtask

    // Monitor: pops an expectation on every pulse and measures how long each note is held.
    bit         m_activo = 1'b0;
    int         m_largo  = 0;
    esp_t       m_e;
    esp_t       m_err;
    logic [7:0] m_actual = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (bus.dato_valido && bus.error_trama) chk("pulsos_simultaneos", 1, 0);
            if (m_activo && !bus.dato_valido) begin
                if (bus.dato == m_actual) m_largo++;
                else begin
                    m_activo = 1'b0;
                    chk("cero_entre_notas", 32'(bus.dato), 0);
                    if (m_e.interrumpido) chk("hold_interrumpido", 32'(m_largo < HOLD), 1);
                    else                  chk("hold_completo", m_largo, HOLD);
                end
            end
            if (bus.dato_valido) begin
                if (m_activo) chk("valido_sin_cero", 1, 0);
                if (cola.size() == 0) chk("valido_inesperado", 1, 0);
                else begin
                    m_e = cola.pop_front();
                    chk("tipo_valido", 32'(m_e.es_error), 0);
                    chk("dato_valido_byte", 32'(bus.dato), 32'(m_e.valor));
                    m_actual = m_e.valor;
                    m_activo = 1'b1;
                    m_largo  = 1;
                end
            end
            if (bus.error_trama) begin
                if (cola.size() == 0) chk("error_inesperado", 1, 0);
                else begin
                    m_err = cola.pop_front();
                    chk("tipo_error", 32'(m_err.es_error), 1);
                    chk("dato_en_error", 32'(bus.dato), 0);
                end
            end
        end
    end

    logic [7:0] r_b   [12];
    bit         r_ok  [12];
    bit         r_cor [12];
    int         lat;

    initial begin
        bus.rx = 1'b1;
        esperar(3);
        chk("reset_dato", 32'(bus.dato), 0);
        chk("reset_valido", 32'(bus.dato_valido), 0);
        chk("reset_error", 32'(bus.error_trama), 0);
        reset = 1'b0;
        esperar(5);

        // 'a' with latency measurement from pin edge to dato_valido
        modelo(8'h61, 1'b1, 1'b0);
        lat = 0;
        fork
            enviar(8'h61, 1'b1);
            begin
                while (lat < 400) begin
                    @(negedge clk);
                    lat++;
                    if (bus.dato_valido) break;
                end
            end
        join
        chk("latencia", lat, LAT);
        esperar(HOLD + 40);

        // back to back: 0x63 is cut short by 0x64's start bit
        enviar_mod(8'h63, 1'b1, 1'b1);
        enviar_mod(8'h64, 1'b1, 1'b0);
        esperar(HOLD + 40);

        // glitch shorter than half a bit
        bus.rx = 1'b0;
        esperar(4);
        bus.rx = 1'b1;
        esperar(CPB * 12);
        chk("glitch_dato", 32'(bus.dato), 0);
        chk("glitch_cola", cola.size(), 0);

        // framing error
        enviar_mod(8'h62, 1'b0, 1'b0);
        esperar(CPB * 2);
        chk("error_dato", 32'(bus.dato), 0);

        // break: one error only, no further reception while low
        modelo(8'h00, 1'b0, 1'b0);
        bus.rx = 1'b0;
        esperar(CPB * 14);
        bus.rx = 1'b1;
        esperar(CPB * 2);
        chk("break_cola", cola.size(), 0);

        // reset in the middle of data bit 4
        bus.rx = 1'b0;
        esperar(CPB);
        for (int i = 0; i < 4; i++) begin
            bus.rx = 1'(8'h61 >> i);
            esperar(CPB);
        end
        bus.rx = 1'b0;
        esperar(CPB / 2);
        reset  = 1'b1;
        bus.rx = 1'b1;
        esperar(1);
        chk("reset_datos_dato", 32'(bus.dato), 0);
        reset = 1'b0;
        esperar(CPB * 10);
        chk("reset_datos_sin_pulso", cola.size(), 0);
        enviar_mod(8'h61, 1'b1, 1'b0);
        esperar(HOLD + 40);

        // reset during hold clears the note
        enviar_mod(8'h64, 1'b1, 1'b1);
        esperar(30);
        reset = 1'b1;
        esperar(1);
        chk("reset_hold_dato", 32'(bus.dato), 0);
        reset = 1'b0;
        esperar(CPB * 4);

        // 'z': filtered or presented
        enviar_mod(8'h7A, 1'b1, 1'b0);
`ifdef FILTRO_NOTAS_EN
        chk("z_dato", 32'(bus.dato), 0);
`else
        chk("z_dato", 32'(bus.dato), 32'h7A);
`endif
        esperar(HOLD + 40);

        // randomised frames with short (interrupting) or long gaps
        for (int i = 0; i < 12; i++) begin
            r_b[i]   = ($urandom_range(0, 1) == 0) ? 8'(97 + $urandom_range(0, 3)) : 8'($urandom_range(1, 255));
            r_ok[i]  = ($urandom_range(0, 5) != 0);
            r_cor[i] = (i < 11) && ($urandom_range(0, 1) == 1);
        end
        for (int i = 0; i < 12; i++) begin
            enviar_mod(r_b[i], r_ok[i], r_cor[i]);
            if (r_cor[i]) esperar($urandom_range(0, 20));
            else          esperar($urandom_range(120, 180));
        end

        esperar(HOLD + 50);
        chk("cola_vacia", cola.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/receptor_nota_serial.md
# receptor_nota_serial

UART 8N1 receiver that turns the keyboard serial line into the held 8-bit note code consumed by the challenge-mode game FSM (its `notaUsuario` input). It presents each received byte as a level for a fixed hold time, then returns to 0. The game FSM detects both "note pressed" and "note released" from that level. It sits between the board RX pin and the game FSM.

## Interface
- `CLKS_PER_BIT`, 5208, clock cycles per bit (50 MHz / 9600 baud); must be ≥ 4.
- `HOLD_CYCLES`, 25_000_000, cycles a valid byte stays on `dato` (0.5 s); must be ≥ 1.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high; returns the block to IDLE.
- `rx`  in  1  raw serial line; idle high; asynchronous to `clk`.
- `dato`  out  8  held received byte; 0 when no note is active.
- `dato_valido`  out  1  one-cycle pulse when `dato` loads a new byte.
- `error_trama`  out  1  one-cycle pulse when a stop bit samples low.

## Operation
- Reset values:
  - `dato` = 0, `dato_valido` = 0, `error_trama` = 0.
  - State = IDLE; synchroniser flops = 1; all counters = 0.
- Synchronisation: `rx` passes through two flops to give `rx_s`. A falling edge is `rx_s` = 0 while the previous `rx_s` = 1.
- States:
  - IDLE: on a falling edge, clear the bit-period counter and go to START.
  - START: after CLKS_PER_BIT/2 (integer division) cycles, sample `rx_s`.
    - If 0, go to DATA with bit index 0.
    - If 1, treat it as a glitch and return to IDLE with no pulse.
  - DATA: every CLKS_PER_BIT cycles, sample `rx_s` into shift bit `index`, LSB first. After index 7 is sampled, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample `rx_s`.
    - If 1: load `dato` with the shifted byte, pulse `dato_valido`, clear the hold counter, go to HOLD.
    - If 0: pulse `error_trama`, leave `dato` unchanged, go to IDLE.
  - HOLD:
    - Hold counter reaches HOLD_CYCLES−1: set `dato` = 0 and go to IDLE.
    - Falling edge on `rx_s` first: set `dato` = 0 on that same edge and go to START. The consumer therefore always sees 0 between consecutive notes.
- Width rules:
  - Bit counter: $clog2(CLKS_PER_BIT) bits.
  - Hold counter: $clog2(HOLD_CYCLES) bits, minimum 1.
  - Bit index: 3 bits.
  - Counters never wrap; each is cleared on every state entry.
- A continuous low line (break) produces exactly one `error_trama`. After that, no further reception occurs until the line returns high and falls again.
- Reset mid-frame or mid-hold:
  - Aborts immediately; `dato` = 0.
  - No pulse is generated.

## Timing
- Pin-to-sample latency: 2 cycles through the synchroniser.
- Start-edge-at-`rx_s` to `dato` update: CLKS_PER_BIT/2 + 9·CLKS_PER_BIT + 1 cycles.
- `dato` is registered and changes only on state transitions. It holds exactly HOLD_CYCLES cycles unless a new start bit interrupts it.
- `dato_valido` and `error_trama`:
  - Registered, high for exactly one cycle.
  - Never high together.
  - `dato_valido` is coincident with the first cycle of the new `dato`.

## Configuration
- `FILTRO_NOTAS_EN` defined:
  - Only bytes 97–100 ('a'–'d') are accepted.
  - Any other correctly framed byte is discarded: `dato` stays 0, no `dato_valido`, return to IDLE, no `error_trama`.
- `FILTRO_NOTAS_EN` undefined: every correctly framed byte is presented.

## Structure
- Shared package holds:
  - ASCII note codes NOTA_A_ASCII = 97 through NOTA_D_ASCII = 100.
  - The 3-bit note encodings (0 = none, 1–4).
  - The receiver state enum.
  - The game FSM uses the same constants.
- One sub-module, `sincronizador_rx`:
  - Two-flop synchroniser with async reset to 1.
  - Outputs `rx_s` and a falling-edge strobe.

## Test plan
Bench parameters: CLKS_PER_BIT = 16, HOLD_CYCLES = 100.
- Send 0x61 ('a') → `dato` = 0x61 for 100 cycles with one `dato_valido`, then 0.
- Send 0x63 then 0x64 back to back:
  - `dato` goes 0x63 → 0 at the second start edge → 0x64.
  - Two `dato_valido` pulses in total.
- Hold `rx` low for 4 cycles only (glitch) → no pulse, `dato` stays 0.
- Send 0x62 with stop bit = 0 → one `error_trama`, `dato` = 0.
- Assert `reset` during DATA bit 4 → `dato` = 0 and IDLE on the next cycle. A following frame with 0x61 is received correctly.
- Send 0x7A ('z'):
  - With FILTRO_NOTAS_EN: `dato` stays 0, no pulse.
  - Without: `dato` = 0x7A.
